// File: rtl/vr_udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX meta/data path between NUM_SRC engines.
// A grant is taken in IDLE, held through the meta beat and every data beat up to
// and including the beat flagged last, so packets never interleave.
// Ready/valid and payload are muxed combinationally from the registered grant.
module vr_udp_tx_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int META_W  = 96,
   parameter int DATA_W  = 256,
   localparam int IDX_W  = $clog2(NUM_SRC)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC-1:0]          src_meta_val,
   input  logic [NUM_SRC*META_W-1:0]   src_meta,
   output logic [NUM_SRC-1:0]          arb_src_meta_rdy,
   input  logic [NUM_SRC-1:0]          src_data_val,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   input  logic [NUM_SRC-1:0]          src_data_last,
   output logic [NUM_SRC-1:0]          arb_src_data_rdy,
   output logic                        arb_udp_meta_val,
   output logic [META_W-1:0]           arb_udp_meta,
   input  logic                        udp_arb_meta_rdy,
   output logic                        arb_udp_data_val,
   output logic [DATA_W-1:0]           arb_udp_data,
   output logic                        arb_udp_data_last,
   input  logic                        udp_arb_data_rdy,
   output logic                        arb_busy,
   output logic [IDX_W-1:0]            arb_grant_idx
);

   // state | meaning
   // IDLE  | no grant; round-robin search over meta requests (1-cycle bubble)
   // META  | granted source's meta beat routed to UDP TX
   // DATA  | granted source's data beats routed until the last beat is accepted

   localparam int CW = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      META = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   grant_next;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_next;
   logic [IDX_W-1:0]   grant_inc;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic [CW-1:0]      cand;
   logic [META_W-1:0]  meta_arr [NUM_SRC];
   logic [DATA_W-1:0]  data_arr [NUM_SRC];

   assign arb_grant_idx = grant_idx;
   assign grant_inc     = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);

   // Split the flat per-source buses into indexable words.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         meta_arr[i] = src_meta[i*META_W +: META_W];
         data_arr[i] = src_data[i*DATA_W +: DATA_W];
      end
   end

   // First requesting source at or after rr_ptr, wrapping at NUM_SRC (works for non-power-of-2).
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = {1'b0, rr_ptr} + CW'(i);
         if (cand >= CW'(NUM_SRC)) begin
            cand = cand - CW'(NUM_SRC);
         end
         if (!pick_found && src_meta_val[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Next-state logic and the combinational routing of the granted source.
   always_comb begin
      state_next        = state;
      grant_next        = grant_idx;
      rr_next           = rr_ptr;
      arb_busy          = 1'b1;
      arb_src_meta_rdy  = '0;
      arb_src_data_rdy  = '0;
      arb_udp_meta_val  = 1'b0;
      arb_udp_meta      = '0;
      arb_udp_data_val  = 1'b0;
      arb_udp_data      = '0;
      arb_udp_data_last = 1'b0;
      case (state)
         IDLE: begin
            arb_busy = 1'b0;
            if (pick_found) begin
               grant_next = pick_idx;
               state_next = META;
            end
         end
         META: begin
            arb_udp_meta_val            = src_meta_val[grant_idx];
            arb_udp_meta                = meta_arr[grant_idx];
            arb_src_meta_rdy[grant_idx] = udp_arb_meta_rdy;
            if (src_meta_val[grant_idx] && udp_arb_meta_rdy) begin
               state_next = DATA;
            end
         end
         DATA: begin
            arb_udp_data_val            = src_data_val[grant_idx];
            arb_udp_data                = data_arr[grant_idx];
            arb_udp_data_last           = src_data_last[grant_idx];
            arb_src_data_rdy[grant_idx] = udp_arb_data_rdy;
            if (src_data_val[grant_idx] && udp_arb_data_rdy && src_data_last[grant_idx]) begin
               rr_next    = grant_inc;
               state_next = IDLE;
            end
         end
         default: begin
            // Unreachable encoding: poison everything so simulation exposes it.
            state_next        = state_t'('x);
            arb_busy          = 1'bx;
            arb_src_meta_rdy  = 'x;
            arb_src_data_rdy  = 'x;
            arb_udp_meta_val  = 1'bx;
            arb_udp_meta      = 'x;
            arb_udp_data_val  = 1'bx;
            arb_udp_data      = 'x;
            arb_udp_data_last = 1'bx;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_next;
         grant_idx <= grant_next;
         rr_ptr    <= rr_next;
      end
   end

endmodule

// File: tb/tb_vr_udp_tx_arbiter.sv
// Directed bench for vr_udp_tx_arbiter (3 sources). A small per-source packet
// generator drives requests; a monitor checks grant order, payload, beat order
// and that only the expected source ever sees ready.
module tb_vr_udp_tx_arbiter;

   localparam int NS = 3;
   localparam int MW = 96;
   localparam int DW = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic [NS-1:0]     src_meta_val;
   logic [NS*MW-1:0]  src_meta;
   logic [NS-1:0]     arb_src_meta_rdy;
   logic [NS-1:0]     src_data_val;
   logic [NS*DW-1:0]  src_data;
   logic [NS-1:0]     src_data_last;
   logic [NS-1:0]     arb_src_data_rdy;
   logic              arb_udp_meta_val;
   logic [MW-1:0]     arb_udp_meta;
   logic              udp_arb_meta_rdy;
   logic              arb_udp_data_val;
   logic [DW-1:0]     arb_udp_data;
   logic              arb_udp_data_last;
   logic              udp_arb_data_rdy;
   logic              arb_busy;
   logic [1:0]        arb_grant_idx;

   vr_udp_tx_arbiter #(.NUM_SRC(NS), .META_W(MW), .DATA_W(DW)) dut (
      .clk               (clk),
      .rst               (rst),
      .src_meta_val      (src_meta_val),
      .src_meta          (src_meta),
      .arb_src_meta_rdy  (arb_src_meta_rdy),
      .src_data_val      (src_data_val),
      .src_data          (src_data),
      .src_data_last     (src_data_last),
      .arb_src_data_rdy  (arb_src_data_rdy),
      .arb_udp_meta_val  (arb_udp_meta_val),
      .arb_udp_meta      (arb_udp_meta),
      .udp_arb_meta_rdy  (udp_arb_meta_rdy),
      .arb_udp_data_val  (arb_udp_data_val),
      .arb_udp_data      (arb_udp_data),
      .arb_udp_data_last (arb_udp_data_last),
      .udp_arb_data_rdy  (udp_arb_data_rdy),
      .arb_busy          (arb_busy),
      .arb_grant_idx     (arb_grant_idx)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // per-source generator state
   bit mp [NS];          // meta beat pending
   int bl [NS];          // data beats left in current packet
   int nbeats [NS];
   int pk [NS];          // packet number
   int pkts_left [NS];
   int exp_q [$];        // expected grant order
   bit in_pkt;
   int n;

   function automatic logic [MW-1:0] meta_of(int s, int p);
      return 96'h1234 + (96'(s) << 16) + (96'(p) << 32);
   endfunction

   function automatic logic [DW-1:0] data_of(int s, int p, int b);
      return 256'hDA7A_0000 + (256'(s) << 16) + (256'(p) << 8) + 256'(b);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         src_meta_val[i]            = mp[i];
         src_meta[i*MW +: MW]       = meta_of(i, pk[i]);
         src_data_val[i]            = (bl[i] > 0);
         src_data[i*DW +: DW]       = data_of(i, pk[i], nbeats[i] - bl[i]);
         src_data_last[i]           = (bl[i] == 1);
      end
   endtask

   task automatic monitor();
      int s;
      if (exp_q.size() != 0)
         chk("rdy_mask", 256'((arb_src_meta_rdy | arb_src_data_rdy) & ~(3'b001 << exp_q[0])), 0);
      else
         chk("rdy_none", 256'(arb_src_meta_rdy | arb_src_data_rdy), 0);
      if (arb_udp_meta_val && udp_arb_meta_rdy) begin
         chk("meta_in_pkt", in_pkt, 0);
         chk("meta_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            s = exp_q[0];
            chk("meta_src", arb_grant_idx, s);
            chk("meta_word", arb_udp_meta, meta_of(s, pk[s]));
         end
         in_pkt = 1'b1;
      end
      if (arb_udp_data_val && udp_arb_data_rdy) begin
         chk("data_in_pkt", in_pkt, 1);
         if (exp_q.size() != 0) begin
            s = exp_q[0];
            chk("data_word", arb_udp_data, data_of(s, pk[s], nbeats[s] - bl[s]));
            chk("data_last", arb_udp_data_last, bl[s] == 1);
            if (bl[s] == 1) begin
               in_pkt = 1'b0;
               void'(exp_q.pop_front());
            end
         end
      end
   endtask

   task automatic update();
      for (int i = 0; i < NS; i++) begin
         if (src_meta_val[i] && arb_src_meta_rdy[i]) mp[i] = 1'b0;
         if (src_data_val[i] && arb_src_data_rdy[i]) begin
            bl[i]--;
            if (bl[i] == 0) begin
               pk[i]++;
               pkts_left[i]--;
               if (pkts_left[i] > 0) begin
                  mp[i] = 1'b1;
                  bl[i] = nbeats[i];
               end
            end
         end
      end
   endtask

   task automatic step();
      monitor();
      update();
      @(posedge clk); #1;
      drive();
      @(negedge clk); #1;
   endtask

   task automatic run(input int budget, output int cyc);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < budget) begin
         step();
         cyc++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic clear_src();
      for (int i = 0; i < NS; i++) begin
         mp[i] = 1'b0; bl[i] = 0; pk[i] = 0; pkts_left[i] = 0; nbeats[i] = 1;
      end
      exp_q.delete();
      in_pkt = 1'b0;
   endtask

   task automatic load(input int s, input int npk, input int nb);
      mp[s] = 1'b1; nbeats[s] = nb; bl[s] = nb; pkts_left[s] = npk;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_src();
      drive();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      udp_arb_meta_rdy = 1'b1;
      udp_arb_data_rdy = 1'b1;
      do_reset();

      // reset state
      chk("rst_busy", arb_busy, 0);
      chk("rst_grant", arb_grant_idx, 0);
      chk("rst_mval", arb_udp_meta_val, 0);
      chk("rst_dval", arb_udp_data_val, 0);
      chk("rst_rdy", 256'(arb_src_meta_rdy | arb_src_data_rdy), 0);

      // 1: single source, single beat
      load(0, 1, 1); exp_q = '{0}; drive(); #1;
      chk("t1_c1_busy", arb_busy, 0);
      chk("t1_c1_mval", arb_udp_meta_val, 0);
      chk("t1_c1_mrdy", arb_src_meta_rdy, 0);
      step();
      chk("t1_c2_busy", arb_busy, 1);
      chk("t1_c2_mval", arb_udp_meta_val, 1);
      chk("t1_c2_meta", arb_udp_meta, 96'h1234);
      chk("t1_c2_mrdy", arb_src_meta_rdy, 3'b001);
      chk("t1_c2_grant", arb_grant_idx, 0);
      step();
      chk("t1_c3_dval", arb_udp_data_val, 1);
      chk("t1_c3_last", arb_udp_data_last, 1);
      chk("t1_c3_drdy", arb_src_data_rdy, 3'b001);
      chk("t1_c3_mval", arb_udp_meta_val, 0);
      step();
      chk("t1_c4_busy", arb_busy, 0);
      chk("t1_c4_dval", arb_udp_data_val, 0);
      // rr_ptr now 1: with 0 and 1 requesting, 1 wins first
      load(0, 1, 1); load(1, 1, 1); exp_q = '{1, 0}; drive(); #1;
      run(40, n);

      // 2: all three continuously, 2-beat packets; 4 cycles per packet
      do_reset();
      load(0, 2, 2); load(1, 2, 2); load(2, 2, 2);
      exp_q = '{0, 1, 2, 0, 1, 2}; drive(); #1;
      run(200, n);
      chk("t2_cycles", n, 24);

      // 3: src1 stalled 5 cycles mid-packet while src2 waits
      load(1, 1, 3); load(2, 1, 1); exp_q = '{1, 2}; drive(); #1;
      step(); step(); step();
      udp_arb_data_rdy = 1'b0; #1;
      for (int k = 0; k < 5; k++) begin
         chk("t3_hold_val", arb_udp_data_val, 1);
         chk("t3_hold_data", arb_udp_data, data_of(1, pk[1], 1));
         chk("t3_hold_grant", arb_grant_idx, 1);
         chk("t3_hold_rdy", 256'(arb_src_meta_rdy | arb_src_data_rdy), 0);
         step();
      end
      udp_arb_data_rdy = 1'b1; #1;
      run(40, n);

      // 4: src1 alone moves rr_ptr to 2; then 0 and 1 request -> wrap to 0 first
      load(1, 1, 1); exp_q = '{1}; drive(); #1;
      run(40, n);
      load(0, 1, 2); load(1, 1, 2); exp_q = '{0, 1}; drive(); #1;
      run(40, n);

      // 5: src2 data_val high during META is not accepted
      do_reset();
      load(2, 1, 1); exp_q = '{2}; drive(); #1;
      chk("t5_c1_drdy", arb_src_data_rdy, 0);
      step();
      chk("t5_c2_mrdy", arb_src_meta_rdy, 3'b100);
      chk("t5_c2_drdy", arb_src_data_rdy, 0);
      chk("t5_c2_dval", arb_udp_data_val, 0);
      step();
      chk("t5_c3_drdy", arb_src_data_rdy, 3'b100);
      run(40, n);

      // 6: reset mid-packet
      do_reset();
      load(1, 1, 1); exp_q = '{1}; drive(); #1;
      run(40, n);
      load(2, 1, 3); exp_q = '{2}; drive(); #1;
      step(); step(); step();
      chk("t6_pre_busy", arb_busy, 1);
      chk("t6_pre_grant", arb_grant_idx, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      clear_src(); drive();
      @(negedge clk); #1;
      chk("t6_busy", arb_busy, 0);
      chk("t6_grant", arb_grant_idx, 0);
      chk("t6_vals", {arb_udp_meta_val, arb_udp_data_val, arb_udp_data_last}, 0);
      chk("t6_rdy", 256'(arb_src_meta_rdy | arb_src_data_rdy), 0);
      rst = 1'b0;
      load(0, 1, 1); load(1, 1, 1); load(2, 1, 1);
      exp_q = '{0, 1, 2}; drive(); #1;
      run(60, n);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
